// File: rtl/multi_ch_throttle_bridge_if.sv
// Bus bundle for multi_ch_throttle_bridge.
// Carries the per-channel request handshakes, the merged response port and the
// credit return pulse. The "master" side is the agent/sink environment and the
// "slave" side is the bridge itself.
interface multi_ch_throttle_bridge_if #(
  parameter int NUM_CH    = 4,
  parameter int DATA_SIZE = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]           req_valid_i;
  logic [NUM_CH*DATA_SIZE-1:0] req_data_i;
  logic [NUM_CH-1:0]           req_ready_o;
  logic                        resp_valid_o;
  logic [DATA_SIZE-1:0]        resp_data_o;
  logic [CH_W-1:0]             resp_ch_o;
  logic                        resp_ready_i;
  logic                        credit_return_i;

  modport master (
    output req_valid_i, req_data_i, resp_ready_i, credit_return_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_ch_o
  );

  modport slave (
    input  req_valid_i, req_data_i, resp_ready_i, credit_return_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_ch_o
  );
endinterface

// File: rtl/multi_ch_throttle_bridge.sv
// multi_ch_throttle_bridge
// NUM_CH request channels, each gated by a throttle FSM (stall window, then an
// open window of COUNT_ON beats) and buffered in a DEPTH-entry FIFO. The FIFOs
// are merged round-robin onto a single response port that may only fire while
// response credits are available.
// Optional feature: define BRIDGE_ERR_EN to add a sticky err_o output that flags
// a credit return arriving while the credit counter is already full.
module multi_ch_throttle_bridge #(
  parameter int NUM_CH    = 4,
  parameter int DATA_SIZE = 16,
  parameter int DEPTH     = 4,
  parameter int COUNT_OFF = 10,
  parameter int COUNT_ON  = 8,
  parameter int CREDITS   = 4,
  parameter     CNFG      = "READY_VALID"
) (
  input logic clk_i,
  input logic rstn_i,
  multi_ch_throttle_bridge_if.slave bus
`ifdef BRIDGE_ERR_EN
  ,
  output logic err_o
`endif
);

  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W   = $clog2(DEPTH + 1);
  localparam int CNT_MAX = (COUNT_OFF > COUNT_ON) ? COUNT_OFF : COUNT_ON;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int CRD_W   = $clog2(CREDITS + 1);
  // A zero-length stall still costs the single cycle out of reset.
  localparam int OFF_LAST = (COUNT_OFF > 0) ? COUNT_OFF - 1 : 0;

  localparam logic [0:0] ST_STALL = 1'b0;
  localparam logic [0:0] ST_OPEN  = 1'b1;
  // With no stall configured, a finished window simply reopens.
  localparam logic [0:0] ST_AFTER_WINDOW = (COUNT_OFF == 0) ? ST_OPEN : ST_STALL;

  localparam bit VALID_READY = (CNFG == "VALID_READY");

  if (!((CNFG == "READY_VALID") || (CNFG == "VALID_READY"))) begin : g_bad_cnfg
    $error("multi_ch_throttle_bridge: CNFG must be READY_VALID or VALID_READY");
  end

  logic [NUM_CH-1:0]    full;
  logic [NUM_CH-1:0]    empty;
  logic [NUM_CH-1:0]    ready;
  logic [NUM_CH-1:0]    accept;
  logic [NUM_CH-1:0]    pop;
  logic [DATA_SIZE-1:0] head [NUM_CH];

  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  scan_grant;
  logic [CH_W-1:0]  grant;
  logic [CH_W-1:0]  lock_ch;
  logic             lock;
  logic             any_pending;
  logic             resp_valid;
  logic             transfer;
  logic [CRD_W-1:0] credits;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [0:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [OCC_W-1:0]     occ;

    assign full[c]   = (occ == OCC_W'(DEPTH));
    assign empty[c]  = (occ == '0);
    assign ready[c]  = (state == ST_OPEN) && !full[c] &&
                       (bus.req_valid_i[c] || !VALID_READY);
    assign accept[c] = bus.req_valid_i[c] && ready[c];
    assign pop[c]    = transfer && (grant == CH_W'(c));
    assign head[c]   = mem[rd_ptr];

    // Throttle: count out the stall window, then allow COUNT_ON beats or bail on a full FIFO.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        state <= ST_STALL;
        cnt   <= '0;
      end else if (state == ST_STALL) begin
        if (cnt == CNT_W'(OFF_LAST)) begin
          state <= ST_OPEN;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        if (full[c] || (accept[c] && (cnt == CNT_W'(COUNT_ON - 1)))) begin
          state <= ST_AFTER_WINDOW;
          cnt   <= '0;
        end else if (accept[c]) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    // Payload storage; contents are don't-care until occupancy says otherwise.
    always_ff @(posedge clk_i) begin
      if (accept[c]) begin
        mem[wr_ptr] <= bus.req_data_i[c*DATA_SIZE +: DATA_SIZE];
      end
    end

    // Circular pointers wrapping at DEPTH and the 0..DEPTH occupancy count.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (accept[c]) begin
          wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
        end
        if (pop[c]) begin
          rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        end
        if (accept[c] && !pop[c]) begin
          occ <= occ + OCC_W'(1);
        end else if (!accept[c] && pop[c]) begin
          occ <= occ - OCC_W'(1);
        end
      end
    end
  end

  // Pick the first non-empty channel at or after the round-robin pointer.
  always_comb begin
    int  idx;
    logic found;
    idx        = 0;
    found      = 1'b0;
    scan_grant = rr_ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (!found && !empty[CH_W'(idx)]) begin
        scan_grant = CH_W'(idx);
        found      = 1'b1;
      end
    end
  end

  assign any_pending = |(~empty);
  assign grant       = lock ? lock_ch : scan_grant;
  assign resp_valid  = (credits != '0) && any_pending;
  assign transfer    = resp_valid && bus.resp_ready_i;

  // A late push to an earlier channel must not steal a response that is already on the bus.
  assign bus.req_ready_o  = ready;
  assign bus.resp_valid_o = resp_valid;
  assign bus.resp_data_o  = resp_valid ? head[grant] : '0;
  assign bus.resp_ch_o    = resp_valid ? grant : '0;

  // Remember a stalled grant and advance the round-robin pointer past each winner.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock    <= 1'b0;
      lock_ch <= '0;
      rr_ptr  <= '0;
    end else begin
      lock    <= resp_valid && !bus.resp_ready_i;
      lock_ch <= grant;
      if (transfer) begin
        rr_ptr <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
      end
    end
  end

  // Credits drop per transfer, rise per return, and saturate at CREDITS.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      credits <= CRD_W'(CREDITS);
    end else if (transfer && !bus.credit_return_i) begin
      credits <= credits - CRD_W'(1);
    end else if (!transfer && bus.credit_return_i && (credits != CRD_W'(CREDITS))) begin
      credits <= credits + CRD_W'(1);
    end
  end

`ifdef BRIDGE_ERR_EN
  // Sticky flag for a return that would push the credit count past its ceiling.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_o <= 1'b0;
    end else if (bus.credit_return_i && !transfer && (credits == CRD_W'(CREDITS))) begin
      err_o <= 1'b1;
    end
  end
`else
  // Without error reporting, a surplus credit return is simply dropped by the saturation above.
`endif

endmodule

// File: tb/tb_multi_ch_throttle_bridge.sv
// Testbench for multi_ch_throttle_bridge: directed corner cases, a vector table
// for arbitration/credit flow, and a randomized run against a queue-based model.
module tb_multi_ch_throttle_bridge;

  localparam int NUM_CH    = 4;
  localparam int DATA_SIZE = 16;
  localparam int DEPTH     = 4;
  localparam int COUNT_OFF = 10;
  localparam int COUNT_ON  = 8;
  localparam int CREDITS   = 4;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  multi_ch_throttle_bridge_if #(.NUM_CH(NUM_CH), .DATA_SIZE(DATA_SIZE)) bus ();
  multi_ch_throttle_bridge_if #(.NUM_CH(NUM_CH), .DATA_SIZE(DATA_SIZE)) bus_vr ();

`ifdef BRIDGE_ERR_EN
  logic err;
  logic err_vr;
`endif

  multi_ch_throttle_bridge #(
    .NUM_CH(NUM_CH), .DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH), .COUNT_OFF(COUNT_OFF),
    .COUNT_ON(COUNT_ON), .CREDITS(CREDITS), .CNFG("READY_VALID")
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .bus(bus)
`ifdef BRIDGE_ERR_EN
    ,
    .err_o(err)
`endif
  );

  multi_ch_throttle_bridge #(
    .NUM_CH(NUM_CH), .DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH), .COUNT_OFF(2),
    .COUNT_ON(COUNT_ON), .CREDITS(CREDITS), .CNFG("VALID_READY")
  ) dut_vr (
    .clk_i(clk),
    .rstn_i(rstn),
    .bus(bus_vr)
`ifdef BRIDGE_ERR_EN
    ,
    .err_o(err_vr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector table for the round-robin / credit sequence
  typedef struct {
    logic        rr;
    logic        cr;
    logic        v;
    logic [1:0]  ch;
    logic [15:0] data;
  } row_t;
  row_t rows [13];

  // Reference model state
  logic [15:0] mq [NUM_CH][$];
  int   m_stall_left [NUM_CH];
  int   m_beats_left [NUM_CH];
  int   m_credits;
  int   m_ptr;
  bit   m_hold;
  int   m_hold_ch;
  int   m_grant;
  logic [NUM_CH-1:0] e_ready;
  logic        e_valid;
  logic [1:0]  e_ch;
  logic [15:0] e_data;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [63:0] d, input logic rr, input logic cr);
    bus.req_valid_i     = v;
    bus.req_data_i      = d;
    bus.resp_ready_i    = rr;
    bus.credit_return_i = cr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    applyStimulus(4'h0, 64'h0, 1'b0, 1'b0);
    bus_vr.req_valid_i     = '0;
    bus_vr.req_data_i      = '0;
    bus_vr.resp_ready_i    = 1'b0;
    bus_vr.credit_return_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 64'(bus.req_ready_o), 64'h0);
    checkOutput("rst_resp_valid", 64'(bus.resp_valid_o), 64'h0);
    checkOutput("rst_resp_data", 64'(bus.resp_data_o), 64'h0);
    checkOutput("rst_resp_ch", 64'(bus.resp_ch_o), 64'h0);
    rstn = 1'b1;
  endtask

  task automatic model_reset;
    for (int c = 0; c < NUM_CH; c++) begin
      mq[c].delete();
      m_stall_left[c] = (COUNT_OFF == 0) ? 1 : COUNT_OFF;
      m_beats_left[c] = COUNT_ON;
    end
    m_credits = CREDITS;
    m_ptr     = 0;
    m_hold    = 1'b0;
    m_hold_ch = 0;
  endtask

  // Expected outputs for the current cycle from model state and current inputs
  task automatic model_eval;
    bit any;
    bit found;
    any   = 1'b0;
    found = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      e_ready[c] = (m_stall_left[c] == 0) && (mq[c].size() < DEPTH);
      if (mq[c].size() > 0) any = 1'b1;
    end
    m_grant = 0;
    if (m_hold) begin
      m_grant = m_hold_ch;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        int idx;
        idx = (m_ptr + i) % NUM_CH;
        if (!found && mq[idx].size() > 0) begin
          m_grant = idx;
          found   = 1'b1;
        end
      end
    end
    e_valid = (m_credits > 0) && any;
    e_ch    = e_valid ? 2'(m_grant) : 2'd0;
    e_data  = e_valid ? mq[m_grant][0] : 16'h0;
  endtask

  // Advance the model across one clock edge using the inputs applied this cycle
  task automatic model_step;
    bit xfer;
    xfer = e_valid && bus.resp_ready_i;
    for (int c = 0; c < NUM_CH; c++) begin
      bit acc;
      acc = bus.req_valid_i[c] && e_ready[c];
      if (m_stall_left[c] > 0) begin
        m_stall_left[c]--;
        if (m_stall_left[c] == 0) m_beats_left[c] = COUNT_ON;
      end else if (acc) begin
        m_beats_left[c]--;
        if (m_beats_left[c] == 0) begin
          m_beats_left[c] = COUNT_ON;
          m_stall_left[c] = COUNT_OFF;
        end
      end else if (mq[c].size() == DEPTH) begin
        m_stall_left[c] = COUNT_OFF;
        m_beats_left[c] = COUNT_ON;
      end
    end
    if (xfer) begin
      void'(mq[m_grant].pop_front());
      m_ptr = (m_grant + 1) % NUM_CH;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.req_valid_i[c] && e_ready[c]) mq[c].push_back(bus.req_data_i[c*DATA_SIZE +: DATA_SIZE]);
    end
    m_hold    = e_valid && !bus.resp_ready_i;
    m_hold_ch = m_grant;
    if (xfer && !bus.credit_return_i) m_credits--;
    else if (!xfer && bus.credit_return_i && m_credits < CREDITS) m_credits++;
  endtask

  initial begin
    int k;
    int cnt;
    logic exp_rdy;

    checks = 0;
    errors = 0;
    rstn   = 1'b0;

    rows[0]  = '{1'b1, 1'b0, 1'b1, 2'd0, 16'hD000};
    rows[1]  = '{1'b1, 1'b0, 1'b1, 2'd1, 16'hD001};
    rows[2]  = '{1'b1, 1'b0, 1'b1, 2'd2, 16'hD002};
    rows[3]  = '{1'b1, 1'b0, 1'b1, 2'd3, 16'hD003};
    rows[4]  = '{1'b1, 1'b0, 1'b0, 2'd0, 16'h0000};
    rows[5]  = '{1'b1, 1'b1, 1'b0, 2'd0, 16'h0000};
    rows[6]  = '{1'b0, 1'b0, 1'b1, 2'd0, 16'hE000};
    rows[7]  = '{1'b1, 1'b1, 1'b1, 2'd0, 16'hE000};
    rows[8]  = '{1'b1, 1'b0, 1'b1, 2'd1, 16'hE001};
    rows[9]  = '{1'b1, 1'b0, 1'b0, 2'd0, 16'h0000};
    rows[10] = '{1'b1, 1'b1, 1'b0, 2'd0, 16'h0000};
    rows[11] = '{1'b1, 1'b0, 1'b1, 2'd2, 16'hE002};
    rows[12] = '{1'b1, 1'b0, 1'b0, 2'd0, 16'h0000};

    // First ready appears exactly 10 cycles after reset release
    do_reset();
    applyStimulus(4'hF, 64'h0004_0003_0002_0001, 1'b1, 1'b1);
    for (int n = 1; n <= 10; n++) begin
      tick();
      checkOutput($sformatf("first_ready_c%0d", n), 64'(bus.req_ready_o), (n >= 10) ? 64'hF : 64'h0);
    end

    // Single draining channel: 8-beat windows separated by 10 stall cycles
    do_reset();
    applyStimulus(4'h1, 64'h0000_0000_0000_1234, 1'b1, 1'b1);
    for (int n = 1; n <= 50; n++) begin
      tick();
      exp_rdy = (n >= 10) && (((n - 10) % 18) < 8);
      checkOutput($sformatf("window_c%0d", n), 64'(bus.req_ready_o[0]), 64'(exp_rdy));
    end

    // Ch0 alone with a blocked sink: fills after 4 beats, head stays put
    do_reset();
    k = 0;
    applyStimulus(4'h1, 64'hA000, 1'b0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      exp_rdy = bus.req_ready_o[0];
      tick();
      if (exp_rdy) begin
        k++;
        bus.req_data_i = 64'(16'hA000 + 16'(k));
      end
      if (k > 0) begin
        checkOutput("full_hold_data", 64'(bus.resp_data_o), 64'hA000);
        checkOutput("full_hold_ch", 64'(bus.resp_ch_o), 64'h0);
      end
    end
    checkOutput("full_accepts", 64'(k), 64'd4);
    checkOutput("full_ready", 64'(bus.req_ready_o[0]), 64'h0);
    checkOutput("full_valid", 64'(bus.resp_valid_o), 64'h1);

    // Round-robin order and credit exhaustion/return, driven from the table
    do_reset();
    applyStimulus(4'h0, 64'h0, 1'b0, 1'b0);
    repeat (10) tick();
    checkOutput("tbl_open", 64'(bus.req_ready_o), 64'hF);
    applyStimulus(4'hF, 64'hD003_D002_D001_D000, 1'b0, 1'b0);
    tick();
    applyStimulus(4'h7, 64'h0000_E002_E001_E000, 1'b0, 1'b0);
    tick();
    for (int r = 0; r < 13; r++) begin
      applyStimulus(4'h0, 64'h0, rows[r].rr, rows[r].cr);
      #1;
      checkOutput($sformatf("tbl%0d_valid", r), 64'(bus.resp_valid_o), 64'(rows[r].v));
      checkOutput($sformatf("tbl%0d_ch", r), 64'(bus.resp_ch_o), 64'(rows[r].ch));
      checkOutput($sformatf("tbl%0d_data", r), 64'(bus.resp_data_o), 64'(rows[r].data));
      tick();
    end

    // Reset in the middle of traffic flushes everything
    do_reset();
    applyStimulus(4'h0, 64'h0, 1'b0, 1'b0);
    repeat (10) tick();
    applyStimulus(4'h1, 64'hF00D, 1'b0, 1'b0);
    repeat (3) tick();
    applyStimulus(4'h0, 64'h0, 1'b0, 1'b0);
    #1;
    checkOutput("pre_rst_valid", 64'(bus.resp_valid_o), 64'h1);
    checkOutput("pre_rst_data", 64'(bus.resp_data_o), 64'hF00D);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_rst_ready", 64'(bus.req_ready_o), 64'h0);
    checkOutput("async_rst_valid", 64'(bus.resp_valid_o), 64'h0);
    checkOutput("async_rst_data", 64'(bus.resp_data_o), 64'h0);
    checkOutput("async_rst_ch", 64'(bus.resp_ch_o), 64'h0);
    tick();
    tick();
    rstn = 1'b1;
    applyStimulus(4'h0, 64'h0, 1'b1, 1'b0);
    for (int n = 0; n < 15; n++) begin
      tick();
      checkOutput("no_stale_valid", 64'(bus.resp_valid_o), 64'h0);
    end
    for (int b = 0; b < 4; b++) begin
      applyStimulus(4'h1, 64'(16'h5000 + 16'(b)), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(4'h2, 64'h0000_0000_5100_0000, 1'b0, 1'b0);
    tick();
    applyStimulus(4'h0, 64'h0, 1'b1, 1'b0);
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      #1;
      if (bus.resp_valid_o) begin
        cnt++;
        checkOutput("post_rst_fresh", 64'(bus.resp_data_o[15:12]), 64'h5);
      end
      tick();
    end
    checkOutput("post_rst_credits", 64'(cnt), 64'd4);

    // VALID_READY: ready follows valid combinationally while OPEN
    do_reset();
    bus_vr.resp_ready_i = 1'b1;
    repeat (4) tick();
    checkOutput("vr_ready_no_valid", 64'(bus_vr.req_ready_o[1]), 64'h0);
    bus_vr.req_valid_i = 4'b0010;
    #1;
    checkOutput("vr_ready_valid", 64'(bus_vr.req_ready_o[1]), 64'h1);
    checkOutput("vr_ready_other", 64'(bus_vr.req_ready_o[0]), 64'h0);
    tick();
    bus_vr.req_valid_i = 4'b0000;

`ifdef BRIDGE_ERR_EN
    // Surplus credit return sets the sticky error
    do_reset();
    checkOutput("err_reset", 64'(err), 64'h0);
    applyStimulus(4'h0, 64'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(4'h0, 64'h0, 1'b0, 1'b0);
    checkOutput("err_set", 64'(err), 64'h1);
    tick();
    checkOutput("err_sticky", 64'(err), 64'h1);
`endif

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      applyStimulus(4'($urandom_range(0, 15)), {$urandom(), $urandom()},
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      #1;
      model_eval();
      checkOutput($sformatf("rnd%0d_ready", cyc), 64'(bus.req_ready_o), 64'(e_ready));
      checkOutput($sformatf("rnd%0d_valid", cyc), 64'(bus.resp_valid_o), 64'(e_valid));
      checkOutput($sformatf("rnd%0d_ch", cyc), 64'(bus.resp_ch_o), 64'(e_ch));
      checkOutput($sformatf("rnd%0d_data", cyc), 64'(bus.resp_data_o), 64'(e_data));
      @(posedge clk);
      model_step();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
